clock_enable_gen: RTL and testbench
===================================

# clock_enable_gen

Multi-channel programmable clock-enable generator for the 48 MHz fabric clock domain. Each channel divides `clk` by a run-time divisor and produces a one-cycle enable strobe, a registered divided square wave and a lock flag. Divisor changes are glitch-free: a new value is accepted through a valid/ready handshake and takes effect only at the channel's next period boundary. A common `sync` input phase-aligns all channels. Downstream logic (ADC sequencing, UART/SPI bit timing) runs on `clk` gated by `ce[i]`, so no extra global buffers are needed.

## Interface
- `CHANNELS`, 4: number of independent divider channels (1..16).
- `DIV_W`, 16: divisor width in bits.
- `RESET_DIV`, 48: divisor loaded into every channel at reset (1 MHz at 48 MHz).
- `CH_W`, max(1, clog2(CHANNELS)): channel-select width (derived, not overridden).

- `clk`  in  1  fabric clock (48 MHz); all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  divisor update request.
- `cfg_ready`  out  1  update slot free for `cfg_chan`.
- `cfg_chan`  in  CH_W  target channel.
- `cfg_div`  in  DIV_W  new divisor; 0 is treated as 1.
- `sync`  in  1  one-cycle pulse that restarts all channels in phase.
- `ce`  out  CHANNELS  per-channel enable strobe, one cycle per period.
- `clk_div`  out  CHANNELS  per-channel divided square wave (registered).
- `locked`  out  CHANNELS  channel has completed a full period since reset/sync.

## Operation
- Per channel i: counter `cnt[i]` (DIV_W bits), active divisor `div_act[i]`, shadow `div_pend[i]`, flag `pend[i]`.
- Reset (`reset`=0): `cnt`=0, `div_act`=RESET_DIV, `pend`=0; `ce`, `clk_div`, `locked` all 0.
- Counting: `cnt_next` = 0 when `cnt` ≥ `div_act`−1, else `cnt`+1. The wrap compare is ≥, so a counter above a reduced divisor wraps immediately.
- Outputs are registered from `cnt_next`: `ce[i]` ← (`cnt_next`==0); `clk_div[i]` ← (`cnt_next` < `div_act`>>1). There is no combinational path from the counter to any port except `cfg_ready`.
- Divisor 1 (or 0): `ce` is high every cycle and `clk_div` stays 0. Divisor 2: `clk_div` toggles every cycle. Odd divisor d: high for (d>>1) cycles, low for d−(d>>1).
- Handshake: `cfg_ready` = ~`pend[cfg_chan]` (combinational). The transfer occurs on `cfg_valid`&`cfg_ready`: `div_pend` ← max(1, `cfg_div`) and `pend` ← 1.
  - If `cfg_chan` ≥ CHANNELS, `cfg_ready`=1 and the transfer is discarded.
- Apply: on the edge where `cnt_next`==0 and `pend`=1, `div_act` ← `div_pend` and `pend` ← 0. The new divisor governs the period that starts at that strobe. The current period is never truncated or stretched.
- A transfer and a wrap on the same edge for the same channel: the value is stored as pending and applied at the following wrap. It is not applied in that edge.
- `locked[i]` is set on the first edge that sets `ce[i]` after reset or sync. It then stays 1 and is unaffected by divisor changes.
- `sync`=1 at an edge acts on all channels: `cnt`←0, `ce`←0, `clk_div`←0, `locked`←0. Any pending divisor is applied immediately and `pend` is cleared.
  - A same-edge cfg transfer is applied immediately to its channel.
  - `sync` overrides a simultaneous wrap.

## Timing
- After `reset` rises, or after a `sync` edge, with divisor D ≥ 2: the first `ce` is high in the cycle following edge D. `ce` then repeats every D cycles, and `locked` rises together with the first `ce`.
- `clk_div` is high for the first D>>1 cycles of every period, beginning with the cycle in which `ce`=1.
- Update latency: the new divisor takes effect at the next strobe after the transfer edge, i.e. at most `div_act` cycles later. `cfg_ready` for that channel is low from the transfer edge until the apply edge.
- Reset assertion mid-period clears all outputs asynchronously. Pending updates are lost.

## Test plan
- Reset release with RESET_DIV=48: `ce[0..3]` high for one cycle at cycles 48, 96, 144; `clk_div` high for 24, low for 24; `locked`=1 from cycle 48.
- Write ch1 div=5 at cycle 10: `cfg_ready`(ch1) goes low. The first 48-cycle period of ch1 completes unchanged, then `ce[1]` occurs every 5 cycles with `clk_div` 2 high/3 low. `cfg_ready` returns high at the apply edge.
- Write ch2 div=0, then div=2: div 0 gives `ce[2]` constant 1 and `clk_div[2]`=0. After the change to 2, `clk_div[2]` alternates every cycle and `ce` is high every other cycle.
- Channels set to 3, 4, 6, 7, then `sync` pulse: all `cnt`=0 and `locked` cleared. `ce` is next seen at +3/+4/+6/+7 cycles, and all four strobes coincide again 84 cycles after sync.
- `sync` coincident with a ch0 cfg transfer (div=10) and a ch3 wrap: ch0 restarts with period 10 immediately, and ch3 produces no strobe on that edge.
- `cfg_chan`=5 with CHANNELS=4: `cfg_ready`=1 and no channel's `div_act` or `pend` changes. Asserting `reset` low mid-period zeroes `ce`, `clk_div` and `locked` without waiting for a clock edge.

Source files
------------

// File: rtl/clock_enable_gen.sv
// Multi-channel programmable clock-enable generator: per-channel divider with
// one-cycle strobe, registered square wave, lock flag and glitch-free divisor updates.
module clock_enable_gen #(
  parameter  int CHANNELS  = 4,
  parameter  int DIV_W     = 16,
  parameter  int RESET_DIV = 48,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                sync,
  output logic [CHANNELS-1:0] ce,
  output logic [CHANNELS-1:0] clk_div,
  output logic [CHANNELS-1:0] locked
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(RESET_DIV);

  // A divisor of zero behaves exactly like a divisor of one.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_ONE : d;
  endfunction

  logic [DIV_W-1:0]    cnt_q      [CHANNELS];
  logic [DIV_W-1:0]    cnt_d      [CHANNELS];
  logic [DIV_W-1:0]    div_act_q  [CHANNELS];
  logic [DIV_W-1:0]    div_act_d  [CHANNELS];
  logic [DIV_W-1:0]    div_pend_q [CHANNELS];
  logic [DIV_W-1:0]    div_pend_d [CHANNELS];
  logic [CHANNELS-1:0] pend_q,    pend_d;
  logic [CHANNELS-1:0] ce_q,      ce_d;
  logic [CHANNELS-1:0] clk_div_q, clk_div_d;
  logic [CHANNELS-1:0] locked_q,  locked_d;

  logic                ready_s;
  logic [CHANNELS-1:0] xfer_s;
  logic [DIV_W-1:0]    new_div_s;

  // Handshake decode; selects beyond the last channel are always ready and dropped.
  always_comb begin
    ready_s   = 1'b1;
    xfer_s    = '0;
    new_div_s = clamp_div(cfg_div);
    for (int i = 0; i < CHANNELS; i++) begin
      ready_s = (cfg_chan == CH_W'(i)) ? ~pend_q[i] : ready_s;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      xfer_s[i] = cfg_valid & ready_s & (cfg_chan == CH_W'(i));
    end
  end

  assign cfg_ready = ready_s;

  // Per-channel next state: count, wrap, apply pending divisor, sync restart.
  always_comb begin
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] div_eff;
    logic             wrap;
    logic             apply;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]      = cnt_q[i];
      div_act_d[i]  = div_act_q[i];
      div_pend_d[i] = div_pend_q[i];
      pend_d[i]     = pend_q[i];
      ce_d[i]       = 1'b0;
      clk_div_d[i]  = 1'b0;
      locked_d[i]   = locked_q[i];

      cnt_nxt = (cnt_q[i] >= (div_act_q[i] - DIV_ONE)) ? '0 : (cnt_q[i] + DIV_ONE);
      wrap    = (cnt_nxt == '0);
      apply   = wrap & pend_q[i];
      // The period starting at this strobe already runs on the new divisor.
      div_eff = apply ? div_pend_q[i] : div_act_q[i];

      if (sync) begin
        cnt_d[i]    = '0;
        ce_d[i]     = 1'b0;
        clk_div_d[i] = 1'b0;
        locked_d[i] = 1'b0;
        pend_d[i]   = 1'b0;
        if (xfer_s[i]) begin
          div_act_d[i] = new_div_s;
        end else if (pend_q[i]) begin
          div_act_d[i] = div_pend_q[i];
        end else begin
          div_act_d[i] = div_act_q[i];
        end
      end else begin
        cnt_d[i]     = cnt_nxt;
        ce_d[i]      = wrap;
        clk_div_d[i] = (cnt_nxt < (div_eff >> 1));
        locked_d[i]  = locked_q[i] | wrap;
        div_act_d[i] = div_eff;
        // A transfer needs pend clear, so it can never collide with an apply.
        if (xfer_s[i]) begin
          div_pend_d[i] = new_div_s;
          pend_d[i]     = 1'b1;
        end else begin
          div_pend_d[i] = div_pend_q[i];
          pend_d[i]     = pend_q[i] & ~apply;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]      <= '0;
        div_act_q[i]  <= DIV_RST;
        div_pend_q[i] <= DIV_RST;
      end
      pend_q    <= '0;
      ce_q      <= '0;
      clk_div_q <= '0;
      locked_q  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]      <= cnt_d[i];
        div_act_q[i]  <= div_act_d[i];
        div_pend_q[i] <= div_pend_d[i];
      end
      pend_q    <= pend_d;
      ce_q      <= ce_d;
      clk_div_q <= clk_div_d;
      locked_q  <= locked_d;
    end
  end

  assign ce      = ce_q;
  assign clk_div = clk_div_q;
  assign locked  = locked_q;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Randomized self-checking bench: a time-based reference model tracks period
// start edges and divisors per channel; a second instance covers out-of-range selects.
module tb_clock_enable_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_chan = 2'd0;
  logic [15:0] cfg_div = 16'd0;
  logic       sync = 1'b0;
  logic [3:0] ce, clk_div, locked;

  logic       cfg_valid5 = 1'b0;
  logic       cfg_ready5;
  logic [2:0] cfg_chan5 = 3'd5;
  logic [7:0] cfg_div5 = 8'd0;
  logic [4:0] ce5, clk_div5, locked5;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  clock_enable_gen #(.CHANNELS(4), .DIV_W(16), .RESET_DIV(48)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_div(cfg_div), .sync(sync),
    .ce(ce), .clk_div(clk_div), .locked(locked));

  clock_enable_gen #(.CHANNELS(5), .DIV_W(8), .RESET_DIV(6)) dut5 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid5), .cfg_ready(cfg_ready5),
    .cfg_chan(cfg_chan5), .cfg_div(cfg_div5), .sync(1'b0),
    .ce(ce5), .clk_div(clk_div5), .locked(locked5));

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: each channel is a sequence of periods, described by the
  // edge on which the current period started and its divisor.
  int   e = 0;
  int   start_m [4];
  int   dcur_m  [4];
  int   dpend_m [4];
  bit   pend_m  [4];
  logic [3:0] ce_m = 4'd0, cd_m = 4'd0, lk_m = 4'd0;
  int   nd;
  bit   xfer;

  initial begin
    for (int i = 0; i < 4; i++) begin
      start_m[i] = 0; dcur_m[i] = 48; dpend_m[i] = 48; pend_m[i] = 1'b0;
    end
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        e = 0;
        ce_m = 4'd0; cd_m = 4'd0; lk_m = 4'd0;
        for (int i = 0; i < 4; i++) begin
          start_m[i] = 0; dcur_m[i] = 48; pend_m[i] = 1'b0;
        end
      end else begin
        e++;
        xfer = cfg_valid && !pend_m[cfg_chan];
        nd = (cfg_div == 16'd0) ? 1 : int'(cfg_div);
        for (int i = 0; i < 4; i++) begin
          if (sync) begin
            start_m[i] = e;
            ce_m[i] = 1'b0; cd_m[i] = 1'b0; lk_m[i] = 1'b0;
            if (xfer && cfg_chan == 2'(i)) dcur_m[i] = nd;
            else if (pend_m[i]) dcur_m[i] = dpend_m[i];
            pend_m[i] = 1'b0;
          end else begin
            if (e == start_m[i] + dcur_m[i]) begin
              start_m[i] = e;
              if (pend_m[i]) begin
                dcur_m[i] = dpend_m[i];
                pend_m[i] = 1'b0;
              end
              ce_m[i] = 1'b1;
              lk_m[i] = 1'b1;
            end else begin
              ce_m[i] = 1'b0;
            end
            cd_m[i] = ((e - start_m[i]) < dcur_m[i] / 2);
            if (xfer && cfg_chan == 2'(i)) begin
              pend_m[i] = 1'b1;
              dpend_m[i] = nd;
            end
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model (and the fixed-divisor second instance).
  always @(negedge clk) begin
    if (reset) begin
      chk("ce", int'(ce), int'(ce_m));
      chk("clk_div", int'(clk_div), int'(cd_m));
      chk("locked", int'(locked), int'(lk_m));
      chk("cfg_ready", int'(cfg_ready), int'(!pend_m[cfg_chan]));
      chk("ce5", int'(ce5), (e > 0 && e % 6 == 0) ? 32'h1F : 0);
      chk("clk_div5", int'(clk_div5), (e > 0 && e % 6 < 3) ? 32'h1F : 0);
      chk("locked5", int'(locked5), (e >= 6) ? 32'h1F : 0);
      chk("cfg_ready5", int'(cfg_ready5), 1);
    end
  end

  // Out-of-range selects on the 5-channel instance must never be accepted.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cfg_valid5 = 1'($urandom_range(0, 1));
      cfg_chan5  = 3'($urandom_range(5, 7));
      cfg_div5   = 8'($urandom_range(0, 4));
    end
  end

  task automatic wait_e(input int t);
    int n = 0;
    while (e < t && n < 20000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (e < t) chk("wait_edge_timeout", e, t);
  endtask

  task automatic write(input logic [1:0] ch, input logic [15:0] d);
    int n = 0;
    bit done = 1'b0;
    cfg_chan = ch;
    cfg_div = d;
    cfg_valid = 1'b1;
    while (!done && n < 500) begin
      @(negedge clk);
      if (cfg_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
      n++;
    end
    cfg_valid = 1'b0;
    if (!done) chk("write_timeout", 0, 1);
  endtask

  int s0;
  int s2;
  int a;
  int b;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ce", int'(ce), 0);
    chk("rst_clk_div", int'(clk_div), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_ready", int'(cfg_ready), 1);
    #2 reset = 1'b1;

    // Ch1 update to 5 while the first 48-cycle period runs.
    wait_e(9);
    cfg_chan = 2'd1; cfg_div = 16'd5; cfg_valid = 1'b1;
    wait_e(10);
    cfg_valid = 1'b0;
    chk("ready_ch1_busy", int'(cfg_ready), 0);
    wait_e(23); chk("clk_div_e23", int'(clk_div), 4'hF);
    wait_e(24); chk("clk_div_e24", int'(clk_div), 4'h0);
    wait_e(47); chk("ce_e47", int'(ce), 4'h0); chk("locked_e47", int'(locked), 4'h0);
    wait_e(48); chk("ce_e48", int'(ce), 4'hF); chk("locked_e48", int'(locked), 4'hF);
    chk("ready_ch1_free", int'(cfg_ready), 1);
    wait_e(52); chk("ce1_e52", int'(ce[1]), 0);
    wait_e(53); chk("ce1_e53", int'(ce[1]), 1); chk("clk_div1_e53", int'(clk_div[1]), 1);
    wait_e(55); chk("clk_div1_e55", int'(clk_div[1]), 0);

    // Ch2: divisor 0 behaves as 1, then divisor 2.
    write(2'd2, 16'd0);
    wait_e(e + 60);
    chk("ce2_div0_a", int'(ce[2]), 1);
    wait_e(e + 1);
    chk("ce2_div0_b", int'(ce[2]), 1);
    chk("clk_div2_div0", int'(clk_div[2]), 0);
    write(2'd2, 16'd2);
    wait_e(e + 5);
    a = int'(ce[2]);
    wait_e(e + 1);
    b = int'(ce[2]);
    chk("ce2_div2_alt", a + b, 1);

    // Divisors 3/4/6/7 followed by a sync pulse.
    write(2'd0, 16'd3);
    write(2'd1, 16'd4);
    write(2'd2, 16'd6);
    write(2'd3, 16'd7);
    sync = 1'b1;
    @(posedge clk);
    #1;
    sync = 1'b0;
    s0 = e;
    #1;
    chk("sync_locked", int'(locked), 0);
    chk("sync_ce", int'(ce), 0);
    wait_e(s0 + 3);  chk("ce_s3", int'(ce), 4'b0001);
    wait_e(s0 + 4);  chk("ce_s4", int'(ce), 4'b0010);
    wait_e(s0 + 6);  chk("ce_s6", int'(ce), 4'b0101);
    wait_e(s0 + 7);  chk("locked_s7", int'(locked), 4'hF);
    wait_e(s0 + 84); chk("ce_s84", int'(ce), 4'hF);

    // Sync on the same edge as a ch0 transfer and a ch3 wrap.
    wait_e(s0 + 90);
    sync = 1'b1; cfg_chan = 2'd0; cfg_div = 16'd10; cfg_valid = 1'b1;
    wait_e(s0 + 91);
    sync = 1'b0; cfg_valid = 1'b0;
    s2 = e;
    chk("ce_sync_wrap", int'(ce), 4'h0);
    wait_e(s2 + 7);  chk("ce_s2_7", int'(ce), 4'b1000);
    wait_e(s2 + 9);  chk("ce0_s2_9", int'(ce[0]), 0);
    wait_e(s2 + 10); chk("ce0_s2_10", int'(ce[0]), 1);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_chan  = 2'($urandom_range(0, 3));
      cfg_div   = 16'($urandom_range(0, 12));
      sync      = ($urandom_range(0, 59) == 0);
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0; sync = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("locked_before_reset", int'(locked), 4'hF);

    // Asynchronous reset in mid-period.
    reset = 1'b0;
    #1;
    chk("areset_ce", int'(ce), 0);
    chk("areset_clk_div", int'(clk_div), 0);
    chk("areset_locked", int'(locked), 0);
    chk("areset_locked5", int'(locked5), 0);
    repeat (2) @(posedge clk);
    #4 reset = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_chan  = 2'($urandom_range(0, 3));
      cfg_div   = 16'($urandom_range(0, 9));
      sync      = ($urandom_range(0, 79) == 0);
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0; sync = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
